// File: rtl/uart_row_packet_parser.sv
// uart_row_packet_parser
// Deframes UART row packets (Y hi, Y lo, BYTE_SIZE_ROW pixel bytes, [checksum],
// stop byte), streams pixel bytes into the frame buffer and answers each
// packet with a one-byte status code through the UART transmitter.
// Optional build macro: PKT_CHECKSUM_EN adds an XOR checksum byte between the
// last pixel byte and the stop byte.
module uart_row_packet_parser #(
  parameter int         BYTE_SIZE_ROW         = 240,
  parameter int         HEIGHT                = 480,
  parameter logic [7:0] STOP_BYTE             = 8'hDD,
  parameter logic [7:0] SUCCESSFULLY_RECEIVED = 8'hFF,
  parameter logic [7:0] NOT_ALL_RECEIVED      = 8'h11,
  parameter int         TIMEOUT_CYCLES        = 200000,
  parameter int         ADDR_W                = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              row_done,
  output logic [9:0]        row_y,
  output logic              err_flag
);

  localparam int IDX_W = (BYTE_SIZE_ROW > 1) ? $clog2(BYTE_SIZE_ROW) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_YHI  = 3'd0;
  localparam logic [2:0] S_YLO  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_STOP = 3'd3;
  localparam logic [2:0] S_ANS  = 3'd4;
`ifdef PKT_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd5;
`endif

  logic [2:0]        state;
  logic [9:0]        y;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              bad;
  logic [7:0]        ans;
  logic              counting;
  logic              tmo_hit;
  logic [ADDR_W-1:0] pix_addr;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // Timeout only runs while a packet is in flight; an incoming byte always
  // restarts it, so a byte arriving on the expiry cycle wins.
`ifdef PKT_CHECKSUM_EN
  assign counting = (state == S_YLO) || (state == S_DATA) ||
                    (state == S_CSUM) || (state == S_STOP);
`else
  assign counting = (state == S_YLO) || (state == S_DATA) || (state == S_STOP);
`endif
  assign tmo_hit  = counting && !rx_done &&
                    (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Full-width row base plus column; bad rows never write, so no wrap concern.
  assign pix_addr = ADDR_W'(y) * ADDR_W'(BYTE_SIZE_ROW) + ADDR_W'(idx);

  // Inter-byte timeout counter.
  always_ff @(posedge clk) begin
    if (rst || rx_done || !counting || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  // Packet FSM with registered write port and answer outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_YHI;
      y        <= '0;
      idx      <= '0;
      bad      <= 1'b0;
      ans      <= 8'h00;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 8'h00;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      row_done <= 1'b0;
      row_y    <= '0;
      err_flag <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      wr_en    <= 1'b0;
      tx_start <= 1'b0;
      row_done <= 1'b0;
      case (state)
        S_YHI: begin
          if (rx_done) begin
            y[9:8] <= rx_data[1:0];
            state  <= S_YLO;
`ifdef PKT_CHECKSUM_EN
            csum   <= rx_data;
`endif
          end
        end
        S_YLO: begin
          if (rx_done) begin
            y[7:0] <= rx_data;
            idx    <= '0;
            bad    <= ({1'b0, y[9:8], rx_data} >= 11'(HEIGHT));
            state  <= S_DATA;
`ifdef PKT_CHECKSUM_EN
            csum   <= csum ^ rx_data;
`endif
          end
        end
        S_DATA: begin
          if (rx_done) begin
            if (!bad) begin
              wr_en   <= 1'b1;
              wr_data <= rx_data;
              wr_addr <= pix_addr;
            end
            idx <= idx + IDX_W'(1);
`ifdef PKT_CHECKSUM_EN
            csum <= csum ^ rx_data;
            if (idx == IDX_W'(BYTE_SIZE_ROW - 1)) state <= S_CSUM;
`else
            if (idx == IDX_W'(BYTE_SIZE_ROW - 1)) state <= S_STOP;
`endif
          end
        end
`ifdef PKT_CHECKSUM_EN
        S_CSUM: begin
          if (rx_done) begin
            if (rx_data != csum) bad <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (rx_done) begin
            ans   <= (rx_data == STOP_BYTE && !bad) ? SUCCESSFULLY_RECEIVED
                                                    : NOT_ALL_RECEIVED;
            state <= S_ANS;
          end
        end
        S_ANS: begin
          // Bytes arriving while the answer is pending are lost; flag it.
          if (rx_done) err_flag <= 1'b1;
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= ans;
            if (ans == SUCCESSFULLY_RECEIVED) begin
              row_done <= 1'b1;
              row_y    <= y;
            end else begin
              err_flag <= 1'b1;
            end
            state <= S_YHI;
          end
        end
        default: state <= S_YHI;
      endcase
      // Expiry aborts the packet; pixels already written are left in place.
      if (tmo_hit) begin
        ans   <= NOT_ALL_RECEIVED;
        state <= S_ANS;
      end
    end
  end

endmodule
